hazard_stall_controller: RTL

Sequences the 5-stage MIPS pipeline around the hazards that operand forwarding cannot resolve. Detects load-use dependencies, tracks the multi-cycle multiply/divide unit (MDU), and applies branch-taken flushes. Drives the PC write enable, the IF/ID write enable and flush, and the ID/EX bubble insert. It sits beside the forwarding unit in the ID/EX region and keeps a saturating stall-cycle counter for performance checks.

---
 rtl/hazard_stall_controller.sv | 117 +++++++++++
 1 files changed

// File: rtl/hazard_stall_controller.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use and HI/LO
// interlocks, branch-taken flush, MDU busy tracking and a stall counter.
module hazard_stall_controller #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic              id_uses_hilo,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rt,
  input  logic              ex_branch_taken,
  input  logic              mdu_start,
  input  logic              mdu_div,
  input  logic              stat_clr,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              mdu_busy,
  output logic [STAT_W-1:0] stall_cycles
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0]  MULT_LD  = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DIV_LD   = CNT_W'(DIV_CYCLES - 1);
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

  typedef enum logic {IDLE, BUSY} mdu_state_e;

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  mdu_cnt_q, mdu_cnt_d;
  logic [STAT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic              load_use, hilo_stall, stall, busy;

  assign busy = (state_q == BUSY);

  // MDU next state: start only accepted in IDLE; BUSY counts down to zero
  always_comb begin
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    case (state_q)
      IDLE: if (mdu_start) begin
        state_d   = BUSY;
        mdu_cnt_d = mdu_div ? DIV_LD : MULT_LD;
      end
      BUSY: if (mdu_cnt_q != '0) mdu_cnt_d = mdu_cnt_q - 1'b1;
            else                 state_d   = IDLE;
      default: begin
        state_d   = IDLE;
        mdu_cnt_d = '0;
      end
    endcase
  end

  // MDU state registers; branch flush deliberately does not touch them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mdu_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  // Hazard detection; a taken branch squashes the dependent instruction
  always_comb begin
    load_use   = ex_mem_read && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    hilo_stall = busy && id_uses_hilo;
    stall      = (load_use || hilo_stall) && !ex_branch_taken;
  end

  // Pipeline control: reset, then flush, then stall, then normal flow
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Stall counter next value: clear wins, increment saturates at all-ones
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stat_clr)                      stall_cycles_d = '0;
    else if (stall && !(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + STAT_ONE;
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (!rst_n) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign mdu_busy     = rst_n && busy;
  assign stall_cycles = stall_cycles_q;

endmodule
